// File: rtl/execute_stage.sv
// execute_stage -- Y86-64 execute stage with the E->M pipeline register.
//
// Computes valE in a W-bit ALU, holds the condition codes {ZF,SF,OF},
// evaluates Cnd for jXX/cmovXX against the CC value before this
// instruction's write, and registers the results into the E->M register.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   stall, bubble      hazard control for the E->M register and CC
//                      (bubble wins over stall; reset wins over both)
//   m_exc              a later stage holds an exception: block the CC write
//   icode, ifun        instruction code / function
//   valA, valB, valC   operands
//   dstE_in, dstM_in   destination register IDs
//   e_*                registered E->M outputs
//   cc                 current {ZF,SF,OF}
//   e_err              registered invalid-instruction flag
//
// Build option: define EXEC_INSTR_ERR_EN to flag invalid encodings on
// e_err (and squash CC/valE/destinations). Undefined, e_err stays 0 and
// invalid encodings fall through the ALU as nops.
module execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         bubble,
  input  logic         m_exc,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  input  logic [3:0]   dstE_in,
  input  logic [3:0]   dstM_in,
  output logic [3:0]   e_icode,
  output logic [W-1:0] e_valE,
  output logic [W-1:0] e_valA,
  output logic         e_cnd,
  output logic [3:0]   e_dstE,
  output logic [3:0]   e_dstM,
  output logic [2:0]   cc,
  output logic         e_err
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  typedef struct packed {
    logic [3:0]   icode;
    logic [W-1:0] valE;
    logic [W-1:0] valA;
    logic         cnd;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic         err;
  } em_t;

  em_t        em_q, em_d, em_load, em_nop;
  logic [2:0] cc_q, cc_d;

  logic [W-1:0] sum, diff, op_r, alu_r;
  logic         op_of;
  logic [2:0]   op_flags;
  logic         zf, sf, of;
  logic         cond, cnd;
  logic         is_cond_op;
  logic         inv;

  // ---------------- ALU ----------------
  always_comb begin
    sum   = valB + valA;
    diff  = valB - valA;
    op_r  = '0;
    op_of = 1'b0;
    case (ifun)
      4'h0: begin
        op_r  = sum;
        op_of = (valA[W-1] == valB[W-1]) && (sum[W-1] != valB[W-1]);
      end
      4'h1: begin
        op_r  = diff;
        op_of = (valB[W-1] != valA[W-1]) && (diff[W-1] != valB[W-1]);
      end
      4'h2:    op_r = valB & valA;
      4'h3:    op_r = valB ^ valA;
      default: op_r = '0;
    endcase
    op_flags = {op_r == '0, op_r[W-1], op_of};

    case (icode)
      I_RRMOV:         alu_r = valA;
      I_IRMOV:         alu_r = valC;
      I_RMMOV, I_MRMOV: alu_r = valB + valC;
      I_OPQ:           alu_r = op_r;
      I_CALL, I_PUSH:  alu_r = valB - W'(8);
      I_RET, I_POP:    alu_r = valB + W'(8);
      default:         alu_r = '0;
    endcase
  end

  // ---------------- Condition evaluation ----------------
  // Uses the stored CC, i.e. the flags as they stand before any OPq in
  // this same cycle writes them; a preceding OPq has already committed.
  always_comb begin
    {zf, sf, of} = cc_q;
    case (ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf ^ of) | zf;
      4'h2:    cond = sf ^ of;
      4'h3:    cond = zf;
      4'h4:    cond = !zf;
      4'h5:    cond = !(sf ^ of);
      4'h6:    cond = !(sf ^ of) && !zf;
      default: cond = 1'b0;
    endcase
    is_cond_op = (icode == I_RRMOV) || (icode == I_JXX);
    cnd        = is_cond_op ? cond : 1'b1;
  end

`ifdef EXEC_INSTR_ERR_EN
  assign inv = (icode > I_POP) ||
               ((icode == I_OPQ) && (ifun > 4'h3)) ||
               (is_cond_op && (ifun > 4'h6));
`else
  assign inv = 1'b0;
`endif

  // ---------------- E->M register / CC next state ----------------
  always_comb begin
    em_nop       = '0;
    em_nop.icode = I_NOP;
    em_nop.dstE  = RNONE;
    em_nop.dstM  = RNONE;

    em_load.icode = icode;
    em_load.valE  = inv ? '0 : alu_r;
    em_load.valA  = valA;
    em_load.cnd   = cnd;
    // A not-taken cmov must not write back.
    em_load.dstE  = (inv || ((icode == I_RRMOV) && !cnd)) ? RNONE : dstE_in;
    em_load.dstM  = inv ? RNONE : dstM_in;
    em_load.err   = inv;

    if (bubble)     em_d = em_nop;
    else if (stall) em_d = em_q;
    else            em_d = em_load;

    cc_d = cc_q;
    if ((icode == I_OPQ) && !stall && !bubble && !m_exc && !inv)
      cc_d = op_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      em_q.icode <= I_NOP;
      em_q.valE  <= '0;
      em_q.valA  <= '0;
      em_q.cnd   <= 1'b0;
      em_q.dstE  <= RNONE;
      em_q.dstM  <= RNONE;
      em_q.err   <= 1'b0;
      cc_q       <= 3'b100;
    end else begin
      em_q <= em_d;
      cc_q <= cc_d;
    end
  end

  assign e_icode = em_q.icode;
  assign e_valE  = em_q.valE;
  assign e_valA  = em_q.valA;
  assign e_cnd   = em_q.cnd;
  assign e_dstE  = em_q.dstE;
  assign e_dstM  = em_q.dstM;
  assign e_err   = em_q.err;
  assign cc      = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Table-driven bench for execute_stage. Each record holds one cycle's
// inputs and the E->M outputs / CC expected after the following edge.
// Expected records go into a scoreboard queue when driven and are popped
// and compared one cycle later.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall, bubble, m_exc;
  logic [3:0]  icode, ifun, dstE_in, dstM_in;
  logic [63:0] valA, valB, valC;
  logic [3:0]  e_icode, e_dstE, e_dstM;
  logic [63:0] e_valE, e_valA;
  logic        e_cnd, e_err;
  logic [2:0]  cc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_stage #(.W(64), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .m_exc(m_exc),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE_in(dstE_in), .dstM_in(dstM_in),
    .e_icode(e_icode), .e_valE(e_valE), .e_valA(e_valA), .e_cnd(e_cnd),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .cc(cc), .e_err(e_err)
  );

  typedef struct {
    logic [3:0]  ctl;    // {rst, stall, bubble, m_exc}
    logic [3:0]  ic, ifn;
    logic [63:0] a, b, c;
    logic [3:0]  de, dm;
    logic [3:0]  x_ic;
    logic [63:0] x_e, x_a;
    logic        x_cnd;
    logic [3:0]  x_de, x_dm;
    logic [2:0]  x_cc;
    logic        x_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t v(input logic [3:0] ctl, input logic [3:0] ic, input logic [3:0] ifn,
                             input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input logic [3:0] de, input logic [3:0] dm,
                             input logic [3:0] x_ic, input logic [63:0] x_e, input logic [63:0] x_a,
                             input logic x_cnd, input logic [3:0] x_de, input logic [3:0] x_dm,
                             input logic [2:0] x_cc, input logic x_err);
    vec_t r;
    r.ctl = ctl; r.ic = ic; r.ifn = ifn; r.a = a; r.b = b; r.c = c; r.de = de; r.dm = dm;
    r.x_ic = x_ic; r.x_e = x_e; r.x_a = x_a; r.x_cnd = x_cnd;
    r.x_de = x_de; r.x_dm = x_dm; r.x_cc = x_cc; r.x_err = x_err;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  localparam logic [63:0] NEG5 = 64'hFFFF_FFFF_FFFF_FFFB;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  initial begin
    rst = 1'b0; stall = 1'b0; bubble = 1'b0; m_exc = 1'b0;
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;
    dstE_in = 4'hF; dstM_in = 4'hF;

    //            ctl    ic    ifn   a        b        c        de    dm      x_ic  x_e                     x_a      cnd  x_de  x_dm  cc      err
    // 0: reset
    tbl.push_back(v(4'b1000, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF,  4'h1, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 3'b100, 1'b0));
    // 1: sub overflow 0x8000.. - 1
    tbl.push_back(v(4'b0000, 4'h6, 4'h1, 64'd1, MSB, 64'd0, 4'h2, 4'hF,   4'h6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'h2, 4'hF, 3'b001, 1'b0));
    // 2: add 5 + -5 -> ZF
    tbl.push_back(v(4'b0000, 4'h6, 4'h0, 64'd5, NEG5, 64'd0, 4'h3, 4'hF,  4'h6, 64'd0, 64'd5, 1'b1, 4'h3, 4'hF, 3'b100, 1'b0));
    // 3: cmove back-to-back, taken
    tbl.push_back(v(4'b0000, 4'h2, 4'h3, 64'd100, 64'd0, 64'd0, 4'h3, 4'hF, 4'h2, 64'd100, 64'd100, 1'b1, 4'h3, 4'hF, 3'b100, 1'b0));
    // 4: cmovne not taken -> dstE squashed
    tbl.push_back(v(4'b0000, 4'h2, 4'h4, 64'd100, 64'd0, 64'd0, 4'h3, 4'hF, 4'h2, 64'd100, 64'd100, 1'b0, 4'hF, 4'hF, 3'b100, 1'b0));
    // 5: pushq, 6: ret, 7: mrmovq, 8: irmovq
    tbl.push_back(v(4'b0000, 4'hA, 4'h0, 64'd7, 64'd200, 64'd0, 4'h4, 4'hF, 4'hA, 64'd192, 64'd7, 1'b1, 4'h4, 4'hF, 3'b100, 1'b0));
    tbl.push_back(v(4'b0000, 4'h9, 4'h0, 64'd0, 64'd200, 64'd0, 4'h4, 4'hF, 4'h9, 64'd208, 64'd0, 1'b1, 4'h4, 4'hF, 3'b100, 1'b0));
    tbl.push_back(v(4'b0000, 4'h5, 4'h0, 64'd0, 64'd100, 64'd8, 4'hF, 4'h6, 4'h5, 64'd108, 64'd0, 1'b1, 4'hF, 4'h6, 3'b100, 1'b0));
    tbl.push_back(v(4'b0000, 4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h7, 4'hF, 4'h3, 64'h1234, 64'd0, 1'b1, 4'h7, 4'hF, 3'b100, 1'b0));
    // 9: xor -> SF
    tbl.push_back(v(4'b0000, 4'h6, 4'h3, MSB, 64'd1, 64'd0, 4'h1, 4'hF,   4'h6, 64'h8000_0000_0000_0001, MSB, 1'b1, 4'h1, 4'hF, 3'b010, 1'b0));
    // 10: jl taken, 11: jge not taken
    tbl.push_back(v(4'b0000, 4'h7, 4'h2, 64'h55, 64'd0, 64'd0, 4'hF, 4'hF, 4'h7, 64'd0, 64'h55, 1'b1, 4'hF, 4'hF, 3'b010, 1'b0));
    tbl.push_back(v(4'b0000, 4'h7, 4'h5, 64'h55, 64'd0, 64'd0, 4'hF, 4'hF, 4'h7, 64'd0, 64'h55, 1'b0, 4'hF, 4'hF, 3'b010, 1'b0));
    // 12,13: stall two cycles during OPq -> everything holds
    tbl.push_back(v(4'b0100, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF, 4'h7, 64'd0, 64'h55, 1'b0, 4'hF, 4'hF, 3'b010, 1'b0));
    tbl.push_back(v(4'b0100, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2, 4'hF, 4'h7, 64'd0, 64'h55, 1'b0, 4'hF, 4'hF, 3'b010, 1'b0));
    // 14: stall+bubble -> nop, CC untouched
    tbl.push_back(v(4'b0110, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF, 4'h1, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 3'b010, 1'b0));
    // 15: OPq with m_exc -> valE registered, CC held
    tbl.push_back(v(4'b0001, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2, 4'hF, 4'h6, 64'd0, 64'd5, 1'b1, 4'h2, 4'hF, 3'b010, 1'b0));
    // 16: reset during stall+bubble
    tbl.push_back(v(4'b1110, 4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'h2, 4'hF, 4'h1, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 3'b100, 1'b0));
`ifdef EXEC_INSTR_ERR_EN
    tbl.push_back(v(4'b0000, 4'hC, 4'h0, 64'd9, 64'd9, 64'd9, 4'h3, 4'h4, 4'hC, 64'd0, 64'd9, 1'b1, 4'hF, 4'hF, 3'b100, 1'b1));
    tbl.push_back(v(4'b0000, 4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'h2, 4'hF, 4'h6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 4'h2, 4'hF, 3'b010, 1'b0));
    tbl.push_back(v(4'b0000, 4'h6, 4'h5, 64'd3, 64'd4, 64'd0, 4'h2, 4'hF, 4'h6, 64'd0, 64'd3, 1'b1, 4'hF, 4'hF, 3'b010, 1'b1));
    tbl.push_back(v(4'b0000, 4'h2, 4'h7, 64'h11, 64'd0, 64'd0, 4'h3, 4'hF, 4'h2, 64'd0, 64'h11, 1'b0, 4'hF, 4'hF, 3'b010, 1'b1));
    tbl.push_back(v(4'b0010, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h2, 4'hF, 4'h1, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 3'b010, 1'b0));
`else
    tbl.push_back(v(4'b0000, 4'hC, 4'h0, 64'd9, 64'd9, 64'd9, 4'h3, 4'h4, 4'hC, 64'd0, 64'd9, 1'b1, 4'h3, 4'h4, 3'b100, 1'b0));
    tbl.push_back(v(4'b0000, 4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'h2, 4'hF, 4'h6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 4'h2, 4'hF, 3'b010, 1'b0));
    // OPq ifun>3 falls through as 0 and still writes ZF
    tbl.push_back(v(4'b0000, 4'h6, 4'h5, 64'd3, 64'd4, 64'd0, 4'h2, 4'hF, 4'h6, 64'd0, 64'd3, 1'b1, 4'h2, 4'hF, 3'b100, 1'b0));
    tbl.push_back(v(4'b0000, 4'h2, 4'h7, 64'h11, 64'd0, 64'd0, 4'h3, 4'hF, 4'h2, 64'h11, 64'h11, 1'b0, 4'hF, 4'hF, 3'b100, 1'b0));
    tbl.push_back(v(4'b0010, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h2, 4'hF, 4'h1, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 3'b100, 1'b0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t x;
      @(negedge clk);
      {rst, stall, bubble, m_exc} = tbl[i].ctl;
      icode = tbl[i].ic; ifun = tbl[i].ifn;
      valA = tbl[i].a; valB = tbl[i].b; valC = tbl[i].c;
      dstE_in = tbl[i].de; dstM_in = tbl[i].dm;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL v%0d scoreboard: got empty queue expected entry", i);
      end else begin
        x = sb.pop_front();
        chk("e_icode", i, 64'(e_icode), 64'(x.x_ic));
        chk("e_valE",  i, e_valE,       x.x_e);
        chk("e_valA",  i, e_valA,       x.x_a);
        chk("e_cnd",   i, 64'(e_cnd),   64'(x.x_cnd));
        chk("e_dstE",  i, 64'(e_dstE),  64'(x.x_de));
        chk("e_dstM",  i, 64'(e_dstM),  64'(x.x_dm));
        chk("cc",      i, 64'(cc),      64'(x.x_cc));
        chk("e_err",   i, 64'(e_err),   64'(x.x_err));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
